// File: rtl/execute_memory_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : execute_memory_pipe_reg
// Purpose  : EX->MEM pipeline register with valid/ready handshake, optional
//            two-entry skid buffer, flush, and a saturating stall counter.
// Revision : 1.0
// ============================================================================
module execute_memory_pipe_reg #(
    parameter int DATA_WIDTH             = 32,
    parameter int REG_FILE_ADDRESS_WIDTH = 5,
    parameter int SKID_EN                = 1,
    parameter int CNT_WIDTH              = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    // EX side
    input  logic                              ValidE,
    output logic                              ReadyE,
    input  logic                              RegWriteE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              MemWriteE,
    input  logic [2:0]                        Funct3E,
    input  logic [DATA_WIDTH-1:0]             ALUResultE,
    input  logic [DATA_WIDTH-1:0]             WriteDataE,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
    input  logic [DATA_WIDTH-1:0]             PCPlus4E,
    input  logic                              FlushE,
    // MEM side
    input  logic                              ReadyM,
    output logic                              ValidM,
    output logic                              RegWriteM,
    output logic [1:0]                        ResultSrcM,
    output logic                              MemWriteM,
    output logic [2:0]                        Funct3M,
    output logic [DATA_WIDTH-1:0]             ALUResultM,
    output logic [DATA_WIDTH-1:0]             WriteDataM,
    output logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    output logic [DATA_WIDTH-1:0]             PCPlus4M,
    output logic [CNT_WIDTH-1:0]              StallCount
);

    localparam int c_BUNDLE_W = 1 + 2 + 1 + 3 + 3 * DATA_WIDTH + REG_FILE_ADDRESS_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BUNDLE_W-1:0] w_bundle_e;
    logic [c_BUNDLE_W-1:0] r_main;
    logic [c_BUNDLE_W-1:0] r_skid;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_valid_m;
    logic                  w_ready_e;
    logic                  w_load_main_e;
    logic                  w_load_main_skid;
    logic                  w_load_skid;
    logic                  w_m_regwrite;
    logic                  w_m_memwrite;

    assign w_bundle_e = {RegWriteE, ResultSrcE, MemWriteE, Funct3E,
                         ALUResultE, WriteDataE, RdE, PCPlus4E};

    assign w_valid_m = (r_state != S_EMPTY);
    assign w_accept  = ValidE & w_ready_e & ~FlushE;
    assign w_drain   = w_valid_m & ReadyM;

    // Flush wins over every transition and leaves the payload untouched.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_e    = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (FlushE) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt   = S_ONE;
                        w_load_main_e = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main_e = 1'b1;
                    end else if (w_accept && (SKID_EN != 0)) begin
                        w_state_nxt = S_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_drain) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic r_ready_e;

            // Ready is registered so the EX stage never sees a path from ReadyM.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ready_e <= 1'b1;
                    r_skid    <= '0;
                end else begin
                    r_ready_e <= (w_state_nxt != S_FULL);
                    if (w_load_skid) begin
                        r_skid <= w_bundle_e;
                    end
                end
            end

            assign w_ready_e = r_ready_e;
        end else begin : g_noskid
            assign w_ready_e = ~w_valid_m | ReadyM;
            assign r_skid    = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_main      <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_e) begin
                r_main <= w_bundle_e;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_valid_m && !ReadyM && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign {w_m_regwrite, ResultSrcM, w_m_memwrite, Funct3M,
            ALUResultM, WriteDataM, RdM, PCPlus4M} = r_main;

    // Side-effecting controls are masked so a stale entry can never write.
    assign RegWriteM  = w_m_regwrite & w_valid_m;
    assign MemWriteM  = w_m_memwrite & w_valid_m;
    assign ValidM     = w_valid_m;
    assign ReadyE     = w_ready_e;
    assign StallCount = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_execute_memory_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_memory_pipe_reg
// Purpose  : Scoreboard bench for the default (skid) and the no-skid/4-bit
//            counter variants driven from one shared stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_execute_memory_pipe_reg;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ValidE, RegWriteE, MemWriteE, FlushE, ReadyM;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;

    logic        a_ready, a_valid, a_rw, a_mw;
    logic [1:0]  a_rs;
    logic [2:0]  a_f3;
    logic [31:0] a_alu, a_wd, a_pc;
    logic [4:0]  a_rd;
    logic [15:0] a_sc;

    logic        b_ready, b_valid, b_rw, b_mw;
    logic [1:0]  b_rs;
    logic [2:0]  b_f3;
    logic [31:0] b_alu, b_wd, b_pc;
    logic [4:0]  b_rd;
    logic [3:0]  b_sc;

    always #5 clk = ~clk;

    execute_memory_pipe_reg u_dut_a (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ReadyE(a_ready),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E), .FlushE(FlushE), .ReadyM(ReadyM),
        .ValidM(a_valid), .RegWriteM(a_rw), .ResultSrcM(a_rs), .MemWriteM(a_mw),
        .Funct3M(a_f3), .ALUResultM(a_alu), .WriteDataM(a_wd), .RdM(a_rd),
        .PCPlus4M(a_pc), .StallCount(a_sc)
    );

    execute_memory_pipe_reg #(.SKID_EN(0), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ValidE(ValidE), .ReadyE(b_ready),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .Funct3E(Funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .RdE(RdE), .PCPlus4E(PCPlus4E), .FlushE(FlushE), .ReadyM(ReadyM),
        .ValidM(b_valid), .RegWriteM(b_rw), .ResultSrcM(b_rs), .MemWriteM(b_mw),
        .Funct3M(b_f3), .ALUResultM(b_alu), .WriteDataM(b_wd), .RdM(b_rd),
        .PCPlus4M(b_pc), .StallCount(b_sc)
    );

    // Reference state: expected entry order per variant plus stall counters.
    bundle_t qa[$];
    bundle_t qb[$];
    bit      rdy_a = 1'b1;
    int      sc_a  = 0;
    int      sc_b  = 0;
    int      n_pass  = 0;
    int      n_total = 0;
    bit      seen_rd7 = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h at t=%0t", tag, obs, exp, $time);
    endtask

    task automatic drv(input bit v, input logic [31:0] alu, input logic [4:0] rd,
                       input bit mw, input bit rm, input bit fl);
        ValidE     = v;
        ALUResultE = alu;
        RdE        = rd;
        MemWriteE  = mw;
        RegWriteE  = ~mw;
        ResultSrcE = alu[1:0];
        Funct3E    = alu[4:2];
        WriteDataE = ~alu;
        PCPlus4E   = alu + 32'd4;
        ReadyM     = rm;
        FlushE     = fl;
    endtask

    task automatic compare_side(input string tag, input logic vm, input bundle_t obs,
                                input logic [15:0] sc, input bundle_t q[$], input int exp_sc);
        check({tag, "_validm"}, {127'd0, vm}, {127'd0, q.size() > 0});
        if (q.size() > 0) check({tag, "_bundle"}, 128'(obs), 128'(q[0]));
        else check({tag, "_wr_masked"}, {126'd0, obs.rw, obs.mw}, 128'd0);
        check({tag, "_stall"}, {112'd0, sc}, 128'(exp_sc));
    endtask

    // One clock: ready check before the edge, model update at it, outputs after.
    task automatic step();
        bit      acc_a, acc_b, drn_a, drn_b, rdy_b, stl_a, stl_b;
        bundle_t be;
        #1;
        be    = {RegWriteE, ResultSrcE, MemWriteE, Funct3E, ALUResultE, WriteDataE, RdE, PCPlus4E};
        rdy_b = (qb.size() == 0) || ReadyM;
        if (rst_n) begin
            check("a_readye", {127'd0, a_ready}, {127'd0, rdy_a});
            check("b_readye", {127'd0, b_ready}, {127'd0, rdy_b});
        end
        acc_a = ValidE && rdy_a && !FlushE;
        acc_b = ValidE && rdy_b && !FlushE;
        drn_a = (qa.size() > 0) && ReadyM;
        drn_b = (qb.size() > 0) && ReadyM;
        stl_a = (qa.size() > 0) && !ReadyM;
        stl_b = (qb.size() > 0) && !ReadyM;
        @(posedge clk);
        if (!rst_n) begin
            qa.delete(); qb.delete();
            sc_a = 0; sc_b = 0; rdy_a = 1'b1;
        end else begin
            if (stl_a && sc_a < 65535) sc_a++;
            if (stl_b && sc_b < 15) sc_b++;
            if (drn_a) void'(qa.pop_front());
            if (drn_b) void'(qb.pop_front());
            if (FlushE) begin
                qa.delete(); qb.delete();
            end else begin
                if (acc_a) qa.push_back(be);
                if (acc_b) qb.push_back(be);
            end
            rdy_a = (qa.size() < 2);
        end
        @(negedge clk);
        compare_side("a", a_valid, {a_rw, a_rs, a_mw, a_f3, a_alu, a_wd, a_rd, a_pc}, a_sc, qa, sc_a);
        compare_side("b", b_valid, {b_rw, b_rs, b_mw, b_f3, b_alu, b_wd, b_rd, b_pc},
                     {12'd0, b_sc}, qb, sc_b);
        if ((a_valid && a_rd == 5'd7) || (b_valid && b_rd == 5'd7)) seen_rd7 = 1'b1;
    endtask

    initial begin
        // Reset with a valid bundle held on the EX side.
        rst_n = 1'b0;
        drv(1'b1, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        step();
        check("rst_a_alu_zero", 128'(a_alu), 128'd0);
        check("rst_a_readye", {127'd0, a_ready}, 128'd1);
        rst_n = 1'b1;
        step();

        // Streaming at full rate.
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 32'(i), 5'(i), 1'b0, 1'b1, 1'b0);
            step();
        end
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();

        // Backpressure: A held, B into skid, C refused, then drain.
        drv(1'b1, 32'hA, 5'd10, 1'b1, 1'b0, 1'b0); step();
        drv(1'b1, 32'hB, 5'd11, 1'b0, 1'b0, 1'b0); step();
        check("bp_a_readye_low", {127'd0, a_ready}, 128'd0);
        drv(1'b1, 32'hC, 5'd12, 1'b0, 1'b0, 1'b0); step();
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(); step(); step();

        // Flush while FULL with a visible RdE=7 bundle offered.
        drv(1'b1, 32'hA2, 5'd20, 1'b1, 1'b0, 1'b0); step();
        drv(1'b1, 32'hB2, 5'd21, 1'b1, 1'b0, 1'b0); step();
        seen_rd7 = 1'b0;
        drv(1'b1, 32'h77, 5'd7, 1'b1, 1'b0, 1'b1); step();
        check("flush_a_validm", {127'd0, a_valid}, 128'd0);
        check("flush_a_memwrite", {127'd0, a_mw}, 128'd0);
        check("flush_a_readye", {127'd0, a_ready}, 128'd1);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(); step();
        check("flush_rd7_never", {127'd0, seen_rd7}, 128'd0);

        // No-skid variant: refuse under backpressure, then drain+accept together.
        drv(1'b1, 32'h100, 5'd1, 1'b0, 1'b1, 1'b0); step();
        drv(1'b1, 32'h101, 5'd2, 1'b0, 1'b0, 1'b0); step();
        drv(1'b1, 32'h102, 5'd3, 1'b0, 1'b1, 1'b0); step();
        check("ns_b_validm_kept", {127'd0, b_valid}, 128'd1);

        // Stall-counter saturation on the 4-bit variant; flush must not clear it.
        drv(1'b1, 32'h200, 5'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step();
        check("sat_b_15", {124'd0, b_sc}, 128'd15);
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1); step();
        check("flush_keeps_b_stall", {124'd0, b_sc}, 128'd15);

        // Reset in the middle of a stall discards both entries.
        drv(1'b1, 32'h300, 5'd5, 1'b0, 1'b0, 1'b0); step(); step(); step();
        rst_n = 1'b0; step();
        check("midrst_a_stall", 128'(a_sc), 128'd0);
        rst_n = 1'b1;

        // Mixed traffic.
        for (int i = 0; i < 60; i++) begin
            drv(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(8, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 11) == 0));
            step();
        end
        drv(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(); step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
